hazard_scoreboard: RTL and testbench

//  Next-generation hazard unit for the 5-stage pipeline (F/D/E/M/W). It provides:
//  - E- and D-stage forwarding selects.
//  - Load-use, branch and jump hazard control.
//  - A pending-write scoreboard for a pipelined multi-cycle multiply/divide unit.

---
 rtl/hazard_scoreboard.sv | 173 +++++++++++++++++
 tb/tb_hazard_scoreboard.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage pipeline: E/D forwarding, load-use/branch/jump control,
// and a pending-write scoreboard tracking a pipelined multi-cycle multiply/divide unit.
module hazard_scoreboard #(
  parameter int REGW   = 5,
  parameter int MD_LAT = 4,
  parameter int NPEND  = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [REGW-1:0] rsD,
  input  logic [REGW-1:0] rtD,
  input  logic [REGW-1:0] rdD,
  input  logic            regwriteD,
  input  logic            mdopD,
  input  logic            branchD,
  input  logic            pcsrcD,
  input  logic            jumpD,
  input  logic [REGW-1:0] rsE,
  input  logic [REGW-1:0] rtE,
  input  logic [REGW-1:0] writeregE,
  input  logic            regwriteE,
  input  logic            memtoregE,
  input  logic            mdopE,
  input  logic [REGW-1:0] writeregM,
  input  logic            regwriteM,
  input  logic            memtoregM,
  input  logic [REGW-1:0] writeregW,
  input  logic            regwriteW,
  output logic [1:0]      forwardAE,
  output logic [1:0]      forwardBE,
  output logic            forwardAD,
  output logic            forwardBD,
  output logic            stallF,
  output logic            stallD,
  output logic            flushD,
  output logic            flushE,
  output logic            md_done,
  output logic [REGW-1:0] md_reg,
  output logic            md_busy
);

  localparam int CW = $clog2(MD_LAT);
  localparam int OW = $clog2(NPEND + 2);

  // Issue/retire protocol: an MD op is accepted on every rising edge where mdopE=1
  // (no back-pressure); md_done is a one-cycle pulse naming md_reg, in issue order.
  logic [NPEND-1:0] r_valid;
  logic [REGW-1:0]  r_dest [NPEND];
  logic [CW-1:0]    r_cnt  [NPEND];
  logic             r_md_done;
  logic [REGW-1:0]  r_md_reg;

  logic [NPEND-1:0] w_retire;
  logic [NPEND-1:0] w_free;
  logic [NPEND-1:0] w_alloc;
  logic             w_found;
  logic [NPEND-1:0] w_valid_nxt;
  logic [REGW-1:0]  w_dest_nxt [NPEND];
  logic [CW-1:0]    w_cnt_nxt  [NPEND];
  logic             w_done_nxt;
  logic [REGW-1:0]  w_reg_nxt;
  logic             w_raw;
  logic             w_waw;
  logic [OW-1:0]    w_vcount;
  logic [OW-1:0]    w_occ;
  logic             w_lw;
  logic             w_br;
  logic             w_mde;
  logic             w_full;
  logic             w_stall;

  // Register 0 is hardwired, so it never produces a dependency.
  function automatic logic hit(input logic [REGW-1:0] a, input logic [REGW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  assign forwardAE = (regwriteM && hit(rsE, writeregM)) ? 2'b01 :
                     (regwriteW && hit(rsE, writeregW)) ? 2'b10 : 2'b00;
  assign forwardBE = (regwriteM && hit(rtE, writeregM)) ? 2'b01 :
                     (regwriteW && hit(rtE, writeregW)) ? 2'b10 : 2'b00;
  assign forwardAD = regwriteM && hit(rsD, writeregM);
  assign forwardBD = regwriteM && hit(rtD, writeregM);

  assign w_lw  = memtoregE && (hit(rsD, writeregE) || hit(rtD, writeregE));
  assign w_br  = branchD &&
                 ((regwriteE && (hit(writeregE, rsD) || hit(writeregE, rtD))) ||
                  (memtoregM && (hit(writeregM, rsD) || hit(writeregM, rtD))));
  assign w_mde = mdopE && (hit(writeregE, rsD) || hit(writeregE, rtD) ||
                           (regwriteD && hit(writeregE, rdD)));

  always_comb begin
    w_raw    = 1'b0;
    w_waw    = 1'b0;
    w_vcount = '0;
    w_retire = '0;
    for (int i = 0; i < NPEND; i++) begin
      if (r_valid[i]) begin
        if (hit(r_dest[i], rsD) || hit(r_dest[i], rtD)) w_raw = 1'b1;
        if (regwriteD && hit(r_dest[i], rdD))            w_waw = 1'b1;
        w_vcount = w_vcount + OW'(1);
        w_retire[i] = (r_cnt[i] == '0);
      end
    end
  end

  // Occupancy as seen by the next edge: the op now in E lands, the retiring one leaves.
  assign w_occ   = w_vcount + OW'(mdopE) - OW'(r_md_done);
  assign w_full  = mdopD && (w_occ == OW'(NPEND));
  assign w_stall = w_lw | w_br | w_mde | w_raw | w_waw | w_full;

  assign stallF  = w_stall;
  assign stallD  = w_stall;
  assign flushE  = w_stall;
  assign flushD  = (pcsrcD | jumpD) & ~w_stall;

  // A retiring slot counts as free so it can be reloaded on the edge that clears it.
  always_comb begin
    w_free     = ~r_valid | w_retire;
    w_alloc    = '0;
    w_found    = 1'b0;
    w_done_nxt = 1'b0;
    w_reg_nxt  = '0;
    for (int i = 0; i < NPEND; i++) begin
      if (mdopE && w_free[i] && !w_found) begin
        w_alloc[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
    for (int i = 0; i < NPEND; i++) begin
      w_valid_nxt[i] = r_valid[i];
      w_dest_nxt[i]  = r_dest[i];
      w_cnt_nxt[i]   = r_cnt[i];
      if (w_alloc[i]) begin
        w_valid_nxt[i] = 1'b1;
        w_dest_nxt[i]  = writeregE;
        w_cnt_nxt[i]   = CW'(MD_LAT - 1);
      end else if (w_retire[i]) begin
        w_valid_nxt[i] = 1'b0;
      end else if (r_valid[i] && (r_cnt[i] != '0)) begin
        w_cnt_nxt[i]   = r_cnt[i] - CW'(1);
      end
      if (w_valid_nxt[i] && (w_cnt_nxt[i] == '0)) begin
        w_done_nxt = 1'b1;
        w_reg_nxt  = w_dest_nxt[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid   <= '0;
      r_dest    <= '{default: '0};
      r_cnt     <= '{default: '0};
      r_md_done <= 1'b0;
      r_md_reg  <= '0;
    end else begin
      r_valid   <= w_valid_nxt;
      r_dest    <= w_dest_nxt;
      r_cnt     <= w_cnt_nxt;
      r_md_done <= w_done_nxt;
      r_md_reg  <= w_reg_nxt;
    end
  end

  assign md_done = r_md_done;
  assign md_reg  = r_md_reg;
  assign md_busy = |r_valid;

  // Issuing into a full scoreboard with nothing retiring loses the op.
  a_md_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(mdopE && (&r_valid) && !(|w_retire)));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus randomized
// traffic checked against a queue-based model of the pending MD writes.
module tb_hazard_scoreboard;
  localparam int REGW   = 5;
  localparam int MD_LAT = 4;
  localparam int NPEND  = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic [REGW-1:0] rsD, rtD, rdD, rsE, rtE, writeregE, writeregM, writeregW;
  logic            regwriteD, mdopD, branchD, pcsrcD, jumpD;
  logic            regwriteE, memtoregE, mdopE, regwriteM, memtoregM, regwriteW;
  logic [1:0]      forwardAE, forwardBE;
  logic            forwardAD, forwardBD, stallF, stallD, flushD, flushE;
  logic            md_done, md_busy;
  logic [REGW-1:0] md_reg;
  logic [9:0]      got_comb;

  int checks = 0;
  int errors = 0;

  // Pending MD writes in issue order: destination and cycles left until md_done.
  logic [REGW-1:0] exp_q[$];
  int              rem_q[$];

  always #5 clk = ~clk;

  hazard_scoreboard #(.REGW(REGW), .MD_LAT(MD_LAT), .NPEND(NPEND)) dut (
    .clk(clk), .reset_n(reset_n),
    .rsD(rsD), .rtD(rtD), .rdD(rdD), .regwriteD(regwriteD), .mdopD(mdopD),
    .branchD(branchD), .pcsrcD(pcsrcD), .jumpD(jumpD),
    .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
    .memtoregE(memtoregE), .mdopE(mdopE),
    .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
    .writeregW(writeregW), .regwriteW(regwriteW),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .forwardAD(forwardAD),
    .forwardBD(forwardBD), .stallF(stallF), .stallD(stallD), .flushD(flushD),
    .flushE(flushE), .md_done(md_done), .md_reg(md_reg), .md_busy(md_busy)
  );

  assign got_comb = {forwardAE, forwardBE, forwardAD, forwardBD, stallF, stallD, flushD, flushE};

  // ---------------- reference model ----------------
  function automatic logic nz_eq(input logic [REGW-1:0] a, input logic [REGW-1:0] b);
    return (a != 0) && (a == b);
  endfunction

  function automatic logic [1:0] ref_fwd_e(input logic [REGW-1:0] src);
    if (regwriteM && nz_eq(src, writeregM)) return 2'b01;
    if (regwriteW && nz_eq(src, writeregW)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic ref_retiring();
    if (exp_q.size() == 0) return 1'b0;
    return rem_q[0] == 0;
  endfunction

  function automatic logic [9:0] ref_comb();
    logic lw, br, mde, raw, waw, full, st, fl;
    int occ;
    lw  = memtoregE && (nz_eq(rsD, writeregE) || nz_eq(rtD, writeregE));
    br  = branchD && ((regwriteE && (nz_eq(writeregE, rsD) || nz_eq(writeregE, rtD))) ||
                      (memtoregM && (nz_eq(writeregM, rsD) || nz_eq(writeregM, rtD))));
    mde = mdopE && (nz_eq(writeregE, rsD) || nz_eq(writeregE, rtD) ||
                    (regwriteD && nz_eq(writeregE, rdD)));
    raw = 1'b0;
    waw = 1'b0;
    foreach (exp_q[i]) begin
      if (nz_eq(exp_q[i], rsD) || nz_eq(exp_q[i], rtD)) raw = 1'b1;
      if (regwriteD && nz_eq(exp_q[i], rdD)) waw = 1'b1;
    end
    occ  = exp_q.size() + int'(mdopE) - int'(ref_retiring());
    full = mdopD && (occ == NPEND);
    st   = lw | br | mde | raw | waw | full;
    fl   = (pcsrcD | jumpD) & ~st;
    return {ref_fwd_e(rsE), ref_fwd_e(rtE), regwriteM && nz_eq(rsD, writeregM),
            regwriteM && nz_eq(rtD, writeregM), st, st, fl, st};
  endfunction

  task automatic model_edge();
    if (!reset_n) begin
      exp_q.delete();
      rem_q.delete();
      return;
    end
    if (ref_retiring()) begin
      void'(exp_q.pop_front());
      void'(rem_q.pop_front());
    end
    foreach (rem_q[i]) rem_q[i] = rem_q[i] - 1;
    if (mdopE && exp_q.size() < NPEND) begin
      exp_q.push_back(writeregE);
      rem_q.push_back(MD_LAT - 1);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    rsD = 0; rtD = 0; rdD = 0; regwriteD = 0; mdopD = 0; branchD = 0; pcsrcD = 0; jumpD = 0;
    rsE = 0; rtE = 0; writeregE = 0; regwriteE = 0; memtoregE = 0; mdopE = 0;
    writeregM = 0; regwriteM = 0; memtoregM = 0; writeregW = 0; regwriteW = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if ({md_done, md_busy} !== 2'b00) begin
      errors++; $display("FAIL reset_md got done/busy=%b exp 00", {md_done, md_busy});
    end
    checks++;
    if (md_reg !== 0) begin
      errors++; $display("FAIL reset_md_reg got %0d exp 0", md_reg);
    end
    checks++;
    if (got_comb !== 10'b0) begin
      errors++; $display("FAIL reset_comb got %b exp 0", got_comb);
    end
    @(negedge clk) reset_n = 1'b1;
    tick();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    rsE = 3; rtE = 3; writeregM = 3; regwriteM = 1; writeregW = 3; regwriteW = 1;
    @(negedge clk);
    checks++;
    if ({forwardAE, forwardBE} !== 4'b0101) begin
      errors++; $display("FAIL fwd_m_prio got %b exp 0101", {forwardAE, forwardBE});
    end
    regwriteM = 0;
    #1;
    checks++;
    if ({forwardAE, forwardBE} !== 4'b1010) begin
      errors++; $display("FAIL fwd_w got %b exp 1010", {forwardAE, forwardBE});
    end
    rsE = 0;
    #1;
    checks++;
    if (forwardAE !== 2'b00) begin
      errors++; $display("FAIL fwd_r0 got %b exp 00", forwardAE);
    end
    tick();
    for (int i = 0; i < 30; i++) begin
      clear_inputs();
      rsE = REGW'($urandom_range(0, 3)); rtE = REGW'($urandom_range(0, 3));
      rsD = REGW'($urandom_range(0, 3)); rtD = REGW'($urandom_range(0, 3));
      writeregM = REGW'($urandom_range(0, 3)); regwriteM = 1'($urandom_range(0, 1));
      writeregW = REGW'($urandom_range(0, 3)); regwriteW = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (got_comb !== ref_comb()) begin
        errors++; $display("FAIL fwd_rand got %b exp %b", got_comb, ref_comb());
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    memtoregE = 1; writeregE = 5; rtD = 5; pcsrcD = 1;
    @(negedge clk);
    checks++;
    if ({stallF, stallD, flushE, flushD} !== 4'b1110) begin
      errors++; $display("FAIL lw_stall got %b exp 1110", {stallF, stallD, flushE, flushD});
    end
    tick();
    memtoregE = 0; pcsrcD = 0;
    @(negedge clk);
    checks++;
    if ({stallF, stallD, flushE, flushD} !== 4'b0000) begin
      errors++; $display("FAIL lw_release got %b exp 0000", {stallF, stallD, flushE, flushD});
    end
    jumpD = 1;
    #1;
    checks++;
    if (flushD !== 1'b1) begin
      errors++; $display("FAIL jump_flush got %b exp 1", flushD);
    end
    tick();
  endtask

  task automatic test_md_latency();
    clear_inputs();
    mdopE = 1; writeregE = 7; rsD = 7;
    @(negedge clk);
    checks++;
    if (stallF !== 1'b1) begin
      errors++; $display("FAIL md_issue_stall got %b exp 1", stallF);
    end
    tick();
    mdopE = 0; writeregE = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({md_done, stallF, md_busy} !== {k == 3, k <= 3, k <= 3}) begin
        errors++; $display("FAIL md_lat k=%0d got done/stall/busy=%b exp %b",
                           k, {md_done, stallF, md_busy}, {k == 3, k <= 3, k <= 3});
      end
      if (k == 3) begin
        checks++;
        if (md_reg !== 7) begin
          errors++; $display("FAIL md_lat_reg got %0d exp 7", md_reg);
        end
      end
      checks++;
      if (got_comb !== ref_comb()) begin
        errors++; $display("FAIL md_lat_model k=%0d got %b exp %b", k, got_comb, ref_comb());
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    mdopE = 1; writeregE = 10;
    tick();
    writeregE = 11;
    tick();
    mdopE = 0; writeregE = 0; mdopD = 1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if ({stallF, md_done} !== {k < 3, k == 3 || k == 4}) begin
        errors++; $display("FAIL b2b k=%0d got stall/done=%b exp %b",
                           k, {stallF, md_done}, {k < 3, k == 3 || k == 4});
      end
      if (k == 3 || k == 4) begin
        checks++;
        if (md_reg !== REGW'(k + 7)) begin
          errors++; $display("FAIL b2b_order k=%0d got %0d exp %0d", k, md_reg, k + 7);
        end
      end
      tick();
    end
    checks++;
    if (md_busy !== 1'b0) begin
      errors++; $display("FAIL b2b_drain got busy=%b exp 0", md_busy);
    end
  endtask

  task automatic test_branch();
    clear_inputs();
    branchD = 1; rsD = 9; regwriteE = 1; writeregE = 9;
    @(negedge clk);
    checks++;
    if (stallF !== 1'b1) begin
      errors++; $display("FAIL br_stall got %b exp 1", stallF);
    end
    tick();
    regwriteE = 0; writeregE = 0; writeregM = 9; regwriteM = 1; memtoregM = 0;
    @(negedge clk);
    checks++;
    if ({forwardAD, stallF} !== 2'b10) begin
      errors++; $display("FAIL br_fwd got fwdAD/stall=%b exp 10", {forwardAD, stallF});
    end
    tick();
  endtask

  task automatic test_async_reset();
    clear_inputs();
    mdopE = 1; writeregE = 12;
    tick();
    writeregE = 13;
    tick();
    mdopE = 0; writeregE = 0; rsD = 12;
    @(negedge clk);
    checks++;
    if ({md_busy, stallF} !== 2'b11) begin
      errors++; $display("FAIL arst_pre got busy/stall=%b exp 11", {md_busy, stallF});
    end
    #2 reset_n = 1'b0;
    exp_q.delete();
    rem_q.delete();
    #1;
    checks++;
    if ({md_busy, md_done, stallF} !== 3'b000 || md_reg !== 0) begin
      errors++; $display("FAIL arst_now got busy/done/stall=%b reg=%0d exp 000 reg=0",
                         {md_busy, md_done, stallF}, md_reg);
    end
    tick();
    @(negedge clk) reset_n = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if ({md_done, stallF, md_busy} !== 3'b000) begin
        errors++; $display("FAIL arst_after k=%0d got done/stall/busy=%b exp 000",
                           k, {md_done, stallF, md_busy});
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset_n   = 1'b1;
      rsD       = REGW'($urandom_range(0, 7)); rtD = REGW'($urandom_range(0, 7));
      rdD       = REGW'($urandom_range(0, 7)); regwriteD = 1'($urandom_range(0, 1));
      mdopD     = ($urandom_range(0, 2) == 0);
      branchD   = ($urandom_range(0, 3) == 0);
      pcsrcD    = ($urandom_range(0, 3) == 0); jumpD = ($urandom_range(0, 5) == 0);
      rsE       = REGW'($urandom_range(0, 7)); rtE = REGW'($urandom_range(0, 7));
      writeregE = REGW'($urandom_range(0, 7)); regwriteE = 1'($urandom_range(0, 1));
      memtoregE = ($urandom_range(0, 3) == 0);
      writeregM = REGW'($urandom_range(0, 7)); regwriteM = 1'($urandom_range(0, 1));
      memtoregM = ($urandom_range(0, 3) == 0);
      writeregW = REGW'($urandom_range(0, 7)); regwriteW = 1'($urandom_range(0, 1));
      mdopE     = ($urandom_range(0, 2) == 0) &&
                  !(exp_q.size() >= NPEND && !ref_retiring());
      @(negedge clk);
      checks++;
      if (got_comb !== ref_comb()) begin
        errors++; $display("FAIL rand_comb n=%0d got %b exp %b", n, got_comb, ref_comb());
      end
      checks++;
      if ({md_done, md_busy} !== {ref_retiring(), exp_q.size() != 0}) begin
        errors++; $display("FAIL rand_md n=%0d got done/busy=%b exp %b",
                           n, {md_done, md_busy}, {ref_retiring(), exp_q.size() != 0});
      end
      if (ref_retiring()) begin
        checks++;
        if (md_reg !== exp_q[0]) begin
          errors++; $display("FAIL rand_md_reg n=%0d got %0d exp %0d", n, md_reg, exp_q[0]);
        end
      end
      if ($urandom_range(0, 49) == 0) begin
        reset_n = 1'b0;
        exp_q.delete();
        rem_q.delete();
        #1;
        checks++;
        if ({md_done, md_busy} !== 2'b00 || md_reg !== 0) begin
          errors++; $display("FAIL rand_arst n=%0d got done/busy=%b reg=%0d exp 00 reg=0",
                             n, {md_done, md_busy}, md_reg);
        end
      end
      tick();
    end
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_md_latency();
    test_back_to_back();
    test_branch();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
